// File: rtl/song_reader.sv
// Song sequencer: walks one song of the internal ROM, handing notes to the player.
// Build option SONG_READER_LOOP_EN repeats the song instead of stopping at the end.
module song_reader #(
   parameter int NOTE_W = 6,
   parameter int DUR_W  = 6,
   parameter int IDX_W  = 5,
   parameter int SONG_W = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              play,
   input  logic [SONG_W-1:0] song,
   input  logic              note_done,
   output logic [NOTE_W-1:0] note,
   output logic [DUR_W-1:0]  duration,
   output logic              new_note,
   output logic              song_done
);

   localparam int WORD_W = NOTE_W + DUR_W;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      CHECK,
      NEW_NOTE,
      WAIT,
      END
   } state_t;

   state_t              state;
   logic [IDX_W-1:0]    idx;
   logic [SONG_W-1:0]   song_latched;
   logic [WORD_W-1:0]   rom_q;
   logic [NOTE_W-1:0]   rom_note;
   logic [DUR_W-1:0]    rom_dur;

   // Song table; a zero duration marks the end of a song.
   function automatic logic [WORD_W-1:0] rom_word(
      input logic [SONG_W-1:0] s,
      input logic [IDX_W-1:0]  i
   );
      int n;
      int d;
      n = 0;
      d = 0;
      case (int'(s))
         0: begin
            case (int'(i))
               0: begin n = 5; d = 4; end
               1: begin n = 9; d = 2; end
               default: ;
            endcase
         end
         1: begin
            case (int'(i))
               0: begin n = 12; d = 3; end
               1: begin n = 0;  d = 1; end
               2: begin n = 20; d = 5; end
               3: begin n = 33; d = 2; end
               default: ;
            endcase
         end
         2: begin
            n = int'(i) * 3 + 7;
            d = int'(i) % 7 + 1;
         end
         3: begin
            case (int'(i))
               0: begin n = 40; d = 6;  end
               1: begin n = 41; d = 1;  end
               2: begin n = 63; d = 63; end
               default: ;
            endcase
         end
         default: ;
      endcase
      return {NOTE_W'(n), DUR_W'(d)};
   endfunction

   always_ff @(posedge clk) begin
      rom_q <= rom_word(song_latched, idx);
   end

   assign rom_note = rom_q[WORD_W-1:DUR_W];
   assign rom_dur  = rom_q[DUR_W-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         idx          <= '0;
         song_latched <= '0;
         note         <= '0;
         duration     <= '0;
         new_note     <= 1'b0;
         song_done    <= 1'b0;
      end else begin
         new_note <= 1'b0;
`ifdef SONG_READER_LOOP_EN
         song_done <= 1'b0;
`endif
         unique case (state)
            IDLE: begin
               if (play) begin
                  song_latched <= song;
                  idx          <= '0;
                  state        <= FETCH;
               end
            end
            FETCH: begin
               if (play) state <= CHECK;
            end
            CHECK: begin
               if (play) begin
                  if (rom_dur == '0) begin
                     state <= END;
                  end else begin
                     note     <= rom_note;
                     duration <= rom_dur;
                     new_note <= 1'b1;
                     state    <= NEW_NOTE;
                  end
               end
            end
            NEW_NOTE: begin
               state <= WAIT;
            end
            WAIT: begin
               // note_done is honoured even while paused
               if (note_done) begin
                  if (idx == '1) begin
                     state <= END;
                  end else begin
                     idx   <= idx + 1'b1;
                     state <= FETCH;
                  end
               end
            end
            END: begin
`ifdef SONG_READER_LOOP_EN
               if (play) begin
                  song_done <= 1'b1;
                  idx       <= '0;
                  state     <= FETCH;
               end
`else
               song_done <= 1'b1;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
